// File: rtl/pll_seq_pkg.sv
// Shared types and widths for the PLL reset sequencer.
// The state encoding is fixed because it is exported on state_dbg.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    HOLD      = 3'd3,
    RUN       = 3'd4
  } seq_state_e;

  // Sized for the largest default cycle count (lock timeout).
  localparam int CNT_W   = $clog2(1048576);
  localparam int RETRY_W = 4;
  localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

endpackage

// File: rtl/bit_sync.sv
// N-flop single-bit synchronizer with asynchronous active-high clear.
// Latency N clk edges; no flow control.
module bit_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[N-2:0], d_i};
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/pll_reset_seq.sv
// PLL lock qualification, lock-timeout watchdog and core reset/enable generation.
// All outputs registered; they reflect the state entered on the same edge.
module pll_reset_seq #(
  parameter int SYNC_STAGES      = 2,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int RESET_HOLD_CYC   = 256,
  parameter int LOCK_TIMEOUT_CYC = 1048576,
  parameter int PLL_RST_CYC      = 16,
  parameter int CE_DIV           = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       reset_req,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ce_pix,
  output logic       ce_half,
  output logic       running,
  output logic [3:0] retry_cnt,
  output logic [2:0] state_dbg
);
  import pll_seq_pkg::*;

  localparam int PH_W = $clog2(CE_DIV);
  localparam logic [CNT_W-1:0] PRST_LAST   = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYC - 1);
  localparam logic [PH_W-1:0]  PH_LAST     = PH_W'(CE_DIV - 1);

  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [PH_W-1:0]    ph_q, ph_d;
  logic               pll_rst_q, sys_reset_q, ce_pix_q, ce_half_q, running_q;
  logic               lock_s;
  logic               active_d;

  bit_sync #(.N(SYNC_STAGES)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d_i (pll_locked),
    .q_o (lock_s)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    retry_d  = retry_q;
    ph_d     = '0;
    active_d = 1'b0;
    case (state_q)
      PLL_RST:   if (cnt_q == PRST_LAST) state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
        end else if (cnt_q == TMO_LAST) begin
          state_d = PLL_RST;
          if (retry_q != RETRY_MAX) retry_d = retry_q + 1'b1;
        end
      end
      STABLE: begin
        if (!lock_s)                     state_d = WAIT_LOCK;
        else if (cnt_q == STABLE_LAST)   state_d = HOLD;
      end
      HOLD: begin
        // A pending menu reset pins the hold count at zero.
        if (!lock_s)                     state_d = WAIT_LOCK;
        else if (reset_req)              cnt_d   = '0;
        else if (cnt_q == HOLD_LAST)     state_d = RUN;
      end
      RUN: begin
        cnt_d = '0;
        if (!lock_s)                     state_d = WAIT_LOCK;
        else if (reset_req)              state_d = HOLD;
      end
      default:                           state_d = PLL_RST;
    endcase
    if (state_d != state_q) cnt_d = '0;

    // Phase restarts on every HOLD entry so the core sees a clean enable pattern.
    active_d = (state_d == HOLD) || (state_d == RUN);
    if (!active_d || (state_d == HOLD && state_q != HOLD)) ph_d = '0;
    else if (ph_q == PH_LAST)                             ph_d = '0;
    else                                                  ph_d = ph_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PLL_RST;
      cnt_q       <= '0;
      retry_q     <= '0;
      ph_q        <= '0;
      pll_rst_q   <= 1'b1;
      sys_reset_q <= 1'b1;
      ce_pix_q    <= 1'b0;
      ce_half_q   <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      ph_q        <= ph_d;
      pll_rst_q   <= (state_d == PLL_RST);
      sys_reset_q <= (state_d != RUN);
      running_q   <= (state_d == RUN);
      ce_pix_q    <= (ph_d == PH_LAST);
      ce_half_q   <= ph_d[0];
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_reset = sys_reset_q;
  assign ce_pix    = ce_pix_q;
  assign ce_half   = ce_half_q;
  assign running   = running_q;
  assign retry_cnt = retry_q;
  assign state_dbg = state_q;

endmodule
